pwm_duty_meter: RTL and testbench

//   Measures an incoming PWM waveform: its period and high time, in clk cycles.

---
 rtl/pwm_duty_meter.sv | 241 ++++++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period and high time of an asynchronous PWM input
// in clk cycles and publishes them with a one-cycle valid strobe. A stuck-high
// or stuck-low input is reported after TIMEOUT cycles without a detected edge.
// Optional build macro PWM_METER_GLITCH_FILTER_EN inserts a FILTER_LEN-cycle
// glitch filter between the synchronizer and the edge detector.
module pwm_duty_meter #(
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 1000000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             stuck_level_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_HIGH,
    S_LOW,
    S_STUCK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input path: synchronizer -> (optional filter) -> edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic lvl;          // filtered input level
  logic lvl_prev_q;   // level one cycle earlier, for edge detection
  logic rise_det, fall_det;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic          filt_level_q, filt_level_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  // Accept a new level only after it has been held for FILTER_LEN cycles.
  always_comb begin
    filt_level_d = filt_level_q;
    filt_cnt_d   = '0;
    if (sync2_q != filt_level_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_level_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // Glitch-filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_level_q <= 1'b0;
      filt_cnt_q   <= '0;
    end else begin
      filt_level_q <= filt_level_d;
      filt_cnt_q   <= filt_cnt_d;
    end
  end

  assign lvl = filt_level_q;
`else
  // Filter disabled: the synchronizer output is the measured level.
  logic filter_len_unused;
  assign filter_len_unused = (FILTER_LEN > 0);
  assign lvl = sync2_q;
`endif

  // Edge-detect register; strobes are one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) lvl_prev_q <= 1'b0;
    else     lvl_prev_q <= lvl;
  end

  assign rise_det = lvl & ~lvl_prev_q;
  assign fall_det = ~lvl & lvl_prev_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM and counters
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;       // cycles since last rise (period / high time)
  logic [CNT_W-1:0] idle_q, idle_d;     // cycles since last edge (timeout)
  logic [CNT_W-1:0] shadow_q, shadow_d; // high time of the period in progress
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;
  logic             timeout;

  // Idle counter has hit the limit; only acted on when no edge this cycle.
  assign timeout = (idle_q >= TIMEOUT_V);

  // Next-state and output logic. Counters start at 1 on an edge so that the
  // value read at the next edge equals the number of cycles between strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    idle_d        = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_ONE;
    shadow_d      = shadow_q;
    period_d      = period_q;
    high_d        = high_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idle_d  = '0;
      stuck_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
          idle_d  = '0;
        end
        S_WAIT_RISE: begin
          if (rise_det) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ONE;
            idle_d  = CNT_ONE;
          end else if (fall_det) begin
            idle_d = CNT_ONE;
          end else if (timeout) begin
            state_d       = S_STUCK;
            period_d      = '0;
            high_d        = '0;
            stuck_d       = 1'b1;
            stuck_level_d = lvl;
            valid_d       = 1'b1;
          end
        end
        S_HIGH: begin
          if (fall_det) begin
            state_d  = S_LOW;
            shadow_d = cnt_q;
            idle_d   = CNT_ONE;
          end else if (timeout) begin
            state_d       = S_STUCK;
            period_d      = '0;
            high_d        = '0;
            stuck_d       = 1'b1;
            stuck_level_d = lvl;
            valid_d       = 1'b1;
          end
        end
        S_LOW: begin
          if (rise_det) begin
            state_d  = S_HIGH;
            period_d = cnt_q;
            high_d   = shadow_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            idle_d   = CNT_ONE;
          end else if (timeout) begin
            state_d       = S_STUCK;
            period_d      = '0;
            high_d        = '0;
            stuck_d       = 1'b1;
            stuck_level_d = lvl;
            valid_d       = 1'b1;
          end
        end
        S_STUCK: begin
          if (rise_det) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ONE;
            idle_d  = CNT_ONE;
          end else if (fall_det) begin
            state_d = S_WAIT_RISE;
            idle_d  = CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idle_d  = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idle_q        <= '0;
      shadow_q      <= '0;
      period_q      <= '0;
      high_q        <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      shadow_q      <= shadow_d;
      period_q      <= period_d;
      high_q        <= high_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign period_o      = period_q;
  assign high_o        = high_q;
  assign valid_o       = valid_q;
  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed testbench for pwm_duty_meter: steady PWM, period change, stuck
// low/high, en drop and reset mid-high, and 2-cycle glitches.
module tb_pwm_duty_meter;

  localparam int CNT_W      = 20;
  localparam int TIMEOUT    = 5000;
  localparam int FILTER_LEN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             stuck_o;
  logic             stuck_level_o;

  always #5 clk = ~clk;

  pwm_duty_meter #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_in       (pwm_in),
    .period_o     (period_o),
    .high_o       (high_o),
    .valid_o      (valid_o),
    .stuck_o      (stuck_o),
    .stuck_level_o(stuck_level_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Record of every published result, captured away from the active edge.
  int q_per[$];
  int q_high[$];
  int q_stk[$];
  int q_lvl[$];
  int prev_valid = 0;
  int dbl_valid  = 0;

  always @(negedge clk) begin
    if (valid_o) begin
      q_per.push_back(int'(period_o));
      q_high.push_back(int'(high_o));
      q_stk.push_back(int'(stuck_o));
      q_lvl.push_back(int'(stuck_level_o));
      $display("valid: period=%0d high=%0d stuck=%0d level=%0d at %0t",
               period_o, high_o, stuck_o, stuck_level_o, $time);
      if (prev_valid != 0) dbl_valid++;
    end
    prev_valid = int'(valid_o);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic check_rec(input string tag, input int idx, input int per,
                           input int hi, input int stk, input int lvl);
    if (idx < q_per.size()) begin
      check_eq({tag, "_period"}, q_per[idx], per);
      check_eq({tag, "_high"}, q_high[idx], hi);
      check_eq({tag, "_stuck"}, q_stk[idx], stk);
      check_eq({tag, "_level"}, q_lvl[idx], lvl);
    end else begin
      check_eq({tag, "_present"}, q_per.size(), idx + 1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_wave(input int period, input int hi, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(period - hi);
    end
  endtask

  // 1000/250 period with a 2-cycle low glitch 100 cycles into the high phase.
  task automatic glitch_wave();
    pwm_in = 1'b1; tick(100);
    pwm_in = 1'b0; tick(2);
    pwm_in = 1'b1; tick(148);
    pwm_in = 1'b0; tick(750);
  endtask

  int base;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(5);
    check_eq("rst_period", int'(period_o), 0);
    check_eq("rst_high", int'(high_o), 0);
    check_eq("rst_valid", int'(valid_o), 0);
    check_eq("rst_stuck", int'(stuck_o), 0);
    check_eq("rst_level", int'(stuck_level_o), 0);
    rst = 1'b0;
    tick(3);

    // Steady 1000/250, then 400/100, then trailing rise; then stuck low
    en = 1'b1;
    tick(20);
    base = q_per.size();
    pwm_wave(1000, 250, 3);
    pwm_wave(400, 100, 2);
    pwm_in = 1'b1; tick(10);
    pwm_in = 1'b0;
    tick(TIMEOUT + 100);
    check_eq("steady_count", q_per.size() - base, 6);
    check_rec("steady0", base + 0, 1000, 250, 0, 0);
    check_rec("steady2", base + 2, 1000, 250, 0, 0);
    check_rec("change0", base + 3, 400, 100, 0, 0);
    check_rec("change1", base + 4, 400, 100, 0, 0);
    check_rec("stuck_lo", base + 5, 0, 0, 1, 0);
    check_eq("stuck_lo_live", int'(stuck_o), 1);

    // en low clears stuck_o; then stuck high
    en = 1'b0;
    tick(5);
    check_eq("en0_stuck", int'(stuck_o), 0);
    pwm_in = 1'b1;
    tick(10);
    base = q_per.size();
    en = 1'b1;
    tick(TIMEOUT + 100);
    check_eq("stuck_hi_level", int'(stuck_level_o), 1);
    pwm_in = 1'b0;
    tick(500);
    check_eq("stuck_hold", int'(stuck_o), 1);
    pwm_wave(1000, 500, 2);
    pwm_in = 1'b1;
    tick(100);
    check_eq("stuck_hi_count", q_per.size() - base, 3);
    check_rec("stuck_hi", base + 0, 0, 0, 1, 1);
    check_rec("recover0", base + 1, 1000, 500, 0, 1);
    check_eq("recover_stuck", int'(stuck_o), 0);

    // en low in the middle of a high phase
    base = q_per.size();
    en = 1'b0;
    tick(10);
    check_eq("en0_valids", q_per.size() - base, 0);
    check_eq("en0_period_hold", int'(period_o), 1000);
    check_eq("en0_high_hold", int'(high_o), 500);
    pwm_in = 1'b0;
    tick(5);
    en = 1'b1;
    tick(20);
    pwm_wave(1000, 300, 2);
    pwm_in = 1'b1;
    tick(100);
    check_eq("reen_count", q_per.size() - base, 2);
    check_rec("reen0", base + 0, 1000, 300, 0, 1);

    // Reset in the middle of a high phase
    rst = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(3);
    check_eq("rst2_period", int'(period_o), 0);
    check_eq("rst2_high", int'(high_o), 0);
    rst = 1'b0;
    tick(20);
    base = q_per.size();
    pwm_wave(800, 200, 1);
    pwm_in = 1'b1; tick(10);
    pwm_in = 1'b0; tick(20);
    check_eq("rst2_count", q_per.size() - base, 1);
    check_rec("rst2_meas", base + 0, 800, 200, 0, 0);

    // 2-cycle glitches on a 1000/250 waveform
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(20);
    base = q_per.size();
    glitch_wave();
    glitch_wave();
    pwm_in = 1'b1; tick(10);
    pwm_in = 1'b0; tick(20);
`ifdef PWM_METER_GLITCH_FILTER_EN
    check_eq("glitch_count", q_per.size() - base, 2);
    check_rec("glitch0", base + 0, 1000, 250, 0, 0);
    check_rec("glitch1", base + 1, 1000, 250, 0, 0);
`else
    check_eq("glitch_count", q_per.size() - base, 4);
    check_rec("glitch0", base + 0, 102, 100, 0, 0);
    check_rec("glitch1", base + 1, 898, 148, 0, 0);
`endif

    check_eq("no_double_valid", dbl_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
